// File: rtl/gfau_seq_pkg.sv
// Shared constants and types for the GFAU instruction sequencer:
// element width, op codes, FSM states and instruction field positions.
package gfau_seq_pkg;

    localparam int SIZE    = 33;
    localparam int INSTR_W = 11;

    localparam int OP_MSB   = 10;
    localparam int OP_LSB   = 9;
    localparam int DST_MSB  = 8;
    localparam int DST_LSB  = 6;
    localparam int SRC0_MSB = 5;
    localparam int SRC0_LSB = 3;
    localparam int SRC1_MSB = 2;
    localparam int SRC1_LSB = 0;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MULT = 2'd2,
        OP_DIV  = 2'd3
    } gfau_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/gfau_seq_regfile.sv
// Operand register file: NREG x SIZE, one synchronous write port and
// three combinational read ports (src0, src1, host read).
module gfau_seq_regfile
    import gfau_seq_pkg::*;
#(
    parameter int SIZE = gfau_seq_pkg::SIZE,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [AW-1:0]   raddr_0,
    input  logic [AW-1:0]   raddr_1,
    input  logic [AW-1:0]   raddr_2,
    output logic [SIZE-1:0] rdata_0,
    output logic [SIZE-1:0] rdata_1,
    output logic [SIZE-1:0] rdata_2
);

    logic [SIZE-1:0] regs_q [NREG];
    logic [SIZE-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_0 = regs_q[raddr_0];
    assign rdata_1 = regs_q[raddr_1];
    assign rdata_2 = regs_q[raddr_2];

endmodule

// File: rtl/gfau_sequencer.sv
// Issues one field-arithmetic instruction at a time to the GFAU and writes the
// result back. Define GFAU_SEQ_TIMEOUT_EN to add the WAIT-state timeout.
//
// state | meaning
// IDLE  | ready for host writes or a new instruction
// ISSUE | operands latched, gfau_start pulsed
// WAIT  | operands held, waiting for gfau_done (or timeout)
// WB    | latched result written to reg[dst], op_done pulsed
module gfau_sequencer
    import gfau_seq_pkg::*;
#(
    parameter int SIZE    = gfau_seq_pkg::SIZE,
    parameter int NREG    = 8,
    parameter int TIMEOUT = 2047
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [SIZE-1:0]          prime,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [INSTR_W-1:0]       instr_data,
    input  logic                     wr_en,
    input  logic [$clog2(NREG)-1:0]  wr_addr,
    input  logic [SIZE-1:0]          wr_data,
    input  logic [$clog2(NREG)-1:0]  rd_addr,
    output logic [SIZE-1:0]          rd_data,
    output logic                     busy,
    output logic                     op_done,
    output logic                     timeout_err,
    output logic [SIZE-1:0]          gfau_in_0,
    output logic [SIZE-1:0]          gfau_in_1,
    output logic [1:0]               gfau_op,
    output logic                     gfau_start,
    input  logic [SIZE-1:0]          gfau_result,
    input  logic                     gfau_done
);

    localparam int AW = $clog2(NREG);

    seq_state_e      state_q, state_d;
    gfau_op_e        op_q, op_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [SIZE-1:0] opa_q, opa_d;
    logic [SIZE-1:0] opb_q, opb_d;
    logic [SIZE-1:0] res_q, res_d;
    logic            terr_q, terr_d;

    logic            accept;
    logic            timeout_hit;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [SIZE-1:0] rf_wdata;
    logic [SIZE-1:0] src0_data, src1_data;

    // The modulus goes straight to the GFAU; the sequencer never inspects it.
    logic unused_prime;
    assign unused_prime = ^prime;

    assign accept = instr_valid && instr_ready;

`ifdef GFAU_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr_q, tmr_d;

    // Down-counter loaded in ISSUE so WAIT gets exactly TIMEOUT cycles.
    always_comb begin
        tmr_d = tmr_q;
        if (state_q == ST_ISSUE) begin
            tmr_d = TW'(TIMEOUT - 1);
        end else if (state_q == ST_WAIT && tmr_q != '0) begin
            tmr_d = tmr_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && !gfau_done && (tmr_q == '0);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (gfau_done) begin
                    state_d = ST_WB;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        gfau_start  = 1'b0;
        op_done     = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_IDLE: begin
                instr_ready = !wr_en;
                busy        = 1'b0;
            end
            ST_ISSUE: gfau_start = 1'b1;
            ST_WB:    op_done    = 1'b1;
            default:  ;
        endcase
    end

    // Operands are captured only at accept, which makes dst/src aliasing safe.
    always_comb begin
        op_d   = op_q;
        dst_d  = dst_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        res_d  = res_q;
        terr_d = terr_q;
        if (accept) begin
            op_d   = gfau_op_e'(instr_data[OP_MSB:OP_LSB]);
            dst_d  = AW'(instr_data[DST_MSB:DST_LSB]);
            opa_d  = src0_data;
            opb_d  = src1_data;
            terr_d = 1'b0;
        end
        if (state_q == ST_WAIT && gfau_done) begin
            res_d = gfau_result;
        end
        if (timeout_hit) begin
            terr_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q   <= OP_ADD;
            dst_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            res_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            dst_q  <= dst_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            res_q  <= res_d;
            terr_q <= terr_d;
        end
    end

    assign rf_we    = (state_q == ST_WB) || (state_q == ST_IDLE && wr_en);
    assign rf_waddr = (state_q == ST_WB) ? dst_q : wr_addr;
    assign rf_wdata = (state_q == ST_WB) ? res_q : wr_data;

    gfau_seq_regfile #(
        .SIZE (SIZE),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_0 (AW'(instr_data[SRC0_MSB:SRC0_LSB])),
        .raddr_1 (AW'(instr_data[SRC1_MSB:SRC1_LSB])),
        .raddr_2 (rd_addr),
        .rdata_0 (src0_data),
        .rdata_1 (src1_data),
        .rdata_2 (rd_data)
    );

    assign gfau_in_0   = opa_q;
    assign gfau_in_1   = opb_q;
    assign gfau_op     = op_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_gfau_sequencer.sv
// Self-checking bench for gfau_sequencer with a latency-programmable GFAU model.
// Build with GFAU_SEQ_TIMEOUT_EN to also exercise the WAIT timeout (TIMEOUT=16).
module tb_gfau_sequencer;
    import gfau_seq_pkg::*;

    localparam int W = 33;
`ifdef GFAU_SEQ_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 2047;
`endif

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [W-1:0]   prime;
    logic           instr_valid;
    logic           instr_ready;
    logic [10:0]    instr_data;
    logic           wr_en;
    logic [2:0]     wr_addr;
    logic [W-1:0]   wr_data;
    logic [2:0]     rd_addr;
    logic [W-1:0]   rd_data;
    logic           busy, op_done, timeout_err;
    logic [W-1:0]   gfau_in_0, gfau_in_1, gfau_result;
    logic [1:0]     gfau_op;
    logic           gfau_start, gfau_done;

    always #5 i_clk = ~i_clk;

    gfau_sequencer #(.SIZE(W), .NREG(8), .TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .prime(prime),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .op_done(op_done), .timeout_err(timeout_err),
        .gfau_in_0(gfau_in_0), .gfau_in_1(gfau_in_1), .gfau_op(gfau_op),
        .gfau_start(gfau_start), .gfau_result(gfau_result), .gfau_done(gfau_done)
    );

    // GFAU model: done is high in cycle start+L+1, result is (a op b) mod p.
    function automatic logic [W-1:0] gf_calc(input logic [1:0] op,
                                             input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] p);
        longint unsigned aa, bb, pp, r, e, base;
        pp = 64'(p);
        if (pp < 2) return '0;
        aa = 64'(a) % pp;
        bb = 64'(b) % pp;
        case (op)
            2'd0: r = (aa + bb) % pp;
            2'd1: r = (aa + pp - bb) % pp;
            2'd2: r = (aa * bb) % pp;
            default: begin
                r = 1; base = bb; e = pp - 2;
                while (e != 0) begin
                    if (e[0]) r = (r * base) % pp;
                    base = (base * base) % pp;
                    e = e >> 1;
                end
                r = (aa * r) % pp;
            end
        endcase
        return r[W-1:0];
    endfunction

    int unsigned lat;
    logic        hang, inj_done;
    int unsigned gcnt;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) gcnt <= 0;
        else if (gfau_start && !hang) gcnt <= lat + 1;
        else if (gcnt != 0) gcnt <= gcnt - 1;
    end
    assign gfau_done   = (gcnt == 1) || inj_done;
    assign gfau_result = gf_calc(gfau_op, gfau_in_0, gfau_in_1, prime);

    // Monitor: samples 1 time unit after the falling edge.
    int cyc = 0;
    int start_cnt, done_cnt, done_cyc, busy_cnt, unstable_cnt;
    logic [W-1:0] prev_a, prev_b;
    logic [1:0]   prev_op;
    logic         prev_busy = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        #1;
        if (gfau_start) start_cnt++;
        if (op_done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
        if (busy && prev_busy &&
            (gfau_in_0 != prev_a || gfau_in_1 != prev_b || gfau_op != prev_op))
            unstable_cnt++;
        prev_a = gfau_in_0; prev_b = gfau_in_1; prev_op = gfau_op; prev_busy = busy;
    end

    int n_vec = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]   dst;
        logic [W-1:0] val;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        gfau_op_e     op;
        logic [2:0]   dst;
        logic [2:0]   s0;
        logic [2:0]   s1;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           l;
        logic [W-1:0] exp;
    } vec_t;

    task automatic clear_counts();
        start_cnt = 0; done_cnt = 0; busy_cnt = 0; unstable_cnt = 0; done_cyc = -1;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [W-1:0] d);
        @(negedge i_clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge i_clk);
        wr_en = 1'b0;
    endtask

    // Returns at the falling edge of the ISSUE cycle.
    task automatic send_instr(input gfau_op_e op, input logic [2:0] dst,
                              input logic [2:0] s0, input logic [2:0] s1,
                              input logic [W-1:0] expv, input bit push, output int acc);
        bit got;
        @(negedge i_clk);
        clear_counts();
        instr_valid = 1'b1;
        instr_data  = {op, dst, s0, s1};
        got = 0; acc = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (instr_ready) begin got = 1; acc = cyc; end
            else @(negedge i_clk);
        end
        check("accept", 64'(got), 64'd1);
        if (push) sb.push_back('{dst, expv});
        @(negedge i_clk);
        instr_valid = 1'b0;
    endtask

    task automatic finish_op(input int acc, input int l, input string tag);
        bit  got;
        sb_t e;
        got = 0;
        for (int k = 0; k < l + 40 && !got; k++) begin
            @(negedge i_clk); #2;
            if (done_cnt != 0) got = 1;
        end
        check({tag, " op_done seen"}, 64'(got), 64'd1);
        check({tag, " op_done latency"}, 64'(done_cyc - acc), 64'(l + 3));
        check({tag, " start pulses"}, 64'(start_cnt), 64'd1);
        check({tag, " operand hold"}, 64'(unstable_cnt), 64'd0);
        @(negedge i_clk);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            rd_addr = e.dst;
            #2;
            check({tag, " result"}, 64'(rd_data), 64'(e.val));
        end
        #1;
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(l + 3));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int acc;

        vecs[0] = '{OP_ADD,  3'd2, 3'd0, 3'd1, 33'd20, 33'd5,  2, 33'd2};
        vecs[1] = '{OP_SUB,  3'd3, 3'd3, 3'd4, 33'd4,  33'd9,  2, 33'd18};
        vecs[2] = '{OP_MULT, 3'd7, 3'd5, 3'd6, 33'd7,  33'd8,  5, 33'd10};
        vecs[3] = '{OP_MULT, 3'd0, 3'd1, 3'd2, 33'd22, 33'd22, 0, 33'd1};
        vecs[4] = '{OP_SUB,  3'd6, 3'd5, 3'd6, 33'd0,  33'd1,  1, 33'd22};
        vecs[5] = '{OP_ADD,  3'd4, 3'd4, 3'd7, 33'd11, 33'd12, 3, 33'd0};
        vecs[6] = '{OP_DIV,  3'd5, 3'd2, 3'd3, 33'd5,  33'd7,  4, 33'd4};

        i_rst = 1'b1; prime = 33'd23; instr_valid = 1'b0; instr_data = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        lat = 2; hang = 1'b0; inj_done = 1'b0;
        clear_counts();

        repeat (3) @(negedge i_clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset gfau_start", 64'(gfau_start), 64'd0);
        check("reset op_done", 64'(op_done), 64'd0);
        check("reset timeout_err", 64'(timeout_err), 64'd0);
        check("reset gfau_op", 64'(gfau_op), 64'd0);
        check("reset gfau_in_0", 64'(gfau_in_0), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("ready after reset", 64'(instr_ready), 64'd1);
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r);
            #1;
            check($sformatf("reset reg%0d", r), 64'(rd_data), 64'd0);
        end

        foreach (vecs[i]) begin
            host_write(vecs[i].s0, vecs[i].a);
            host_write(vecs[i].s1, vecs[i].b);
            lat = 32'(vecs[i].l);
            send_instr(vecs[i].op, vecs[i].dst, vecs[i].s0, vecs[i].s1, vecs[i].exp, 1'b1, acc);
            finish_op(acc, vecs[i].l, $sformatf("vec%0d", i));
        end

        // div, L=40, spurious done during ISSUE: 9/2 mod 23 = 16
        host_write(3'd0, 33'd9);
        host_write(3'd1, 33'd2);
        lat = 40;
        send_instr(OP_DIV, 3'd2, 3'd0, 3'd1, 33'd16, 1'b1, acc);
        inj_done = 1'b1;
        @(negedge i_clk);
        inj_done = 1'b0;
        finish_op(acc, 40, "div stale done");

        // Host write and instruction in the same IDLE cycle: 15 + 2 = 17
        lat = 2;
        @(negedge i_clk);
        clear_counts();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 33'd15;
        instr_valid = 1'b1; instr_data = {OP_ADD, 3'd3, 3'd0, 3'd1};
        #1;
        check("ready low during write", 64'(instr_ready), 64'd0);
        @(negedge i_clk);
        wr_en = 1'b0;
        #1;
        check("ready after write", 64'(instr_ready), 64'd1);
        acc = cyc;
        sb.push_back('{3'd3, 33'd17});
        @(negedge i_clk);
        instr_valid = 1'b0;
        finish_op(acc, 2, "write then instr");

        // Host write while busy is dropped: 15 * 2 = 30 -> 7
        lat = 10;
        send_instr(OP_MULT, 3'd4, 3'd0, 3'd1, 33'd7, 1'b1, acc);
        @(negedge i_clk);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 33'd99;
        #1;
        check("ready low while busy", 64'(instr_ready), 64'd0);
        @(negedge i_clk);
        wr_en = 1'b0;
        finish_op(acc, 10, "write while busy");
        rd_addr = 3'd1;
        #1;
        check("busy write dropped", 64'(rd_data), 64'd2);

        // Reset in WAIT, then a late done after release
        lat = 30;
        send_instr(OP_DIV, 3'd5, 3'd0, 3'd1, '0, 1'b0, acc);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset gfau_op", 64'(gfau_op), 64'd0);
        check("mid reset gfau_in_0", 64'(gfau_in_0), 64'd0);
        check("mid reset gfau_in_1", 64'(gfau_in_1), 64'd0);
        check("mid reset start", 64'(gfau_start), 64'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        done_cnt = 0;
        @(negedge i_clk);
        inj_done = 1'b1;
        @(negedge i_clk);
        inj_done = 1'b0;
        repeat (5) @(negedge i_clk);
        rd_addr = 3'd5;
        #2;
        check("late done op_done", 64'(done_cnt), 64'd0);
        check("late done busy", 64'(busy), 64'd0);
        check("late done no write", 64'(rd_data), 64'd0);

`ifdef GFAU_SEQ_TIMEOUT_EN
        // GFAU never answers: timeout after 16 WAIT cycles, no writeback
        host_write(3'd0, 33'd3);
        host_write(3'd1, 33'd4);
        host_write(3'd2, 33'd5);
        hang = 1'b1;
        send_instr(OP_MULT, 3'd2, 3'd0, 3'd1, '0, 1'b0, acc);
        repeat (16) @(negedge i_clk);
        #2;
        check("last WAIT busy", 64'(busy), 64'd1);
        check("last WAIT timeout_err", 64'(timeout_err), 64'd0);
        @(negedge i_clk);
        #2;
        check("timeout busy", 64'(busy), 64'd0);
        check("timeout_err set", 64'(timeout_err), 64'd1);
        check("timeout op_done", 64'(done_cnt), 64'd0);
        rd_addr = 3'd2;
        #1;
        check("timeout no write", 64'(rd_data), 64'd5);
        hang = 1'b0;
        lat = 1;
        send_instr(OP_ADD, 3'd2, 3'd0, 3'd1, 33'd7, 1'b1, acc);
        #2;
        check("timeout_err cleared", 64'(timeout_err), 64'd0);
        finish_op(acc, 1, "after timeout");
`else
        check("timeout_err stays low", 64'(timeout_err), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
